// File: rtl/dct16_seq.sv
// Two-pass sequencer for the 16-point DCT core (rows, then transposed columns); capture tags trail core_load by LATENCY cycles.
// Input is throttled by a downstream credit count because the core cannot stall; in_ready depends on registered state only.
module dct16_seq #(
  parameter int LATENCY = 6,
  parameter int ROWS    = 16,
  parameter int CREDITS = 8,
  parameter int IDX_W   = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             err_start_o,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic             core_load_o,
  output logic             pass_o,
  output logic [IDX_W-1:0] feed_idx_o,
  output logic             cap_en_o,
  output logic             cap_pass_o,
  output logic [IDX_W-1:0] cap_idx_o,
  input  logic             buf_pop_i,
  output logic [4:0]       credits_o,
  output logic             block_done_o
);

  typedef enum logic [2:0] {
    IDLE,
    FEED_ROW,
    DRAIN_ROW,
    FEED_COL,
    DRAIN_COL,
    DONE
  } state_t;

  typedef struct packed {
    logic             vld;
    logic             pass;
    logic [IDX_W-1:0] idx;
  } tag_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);
  localparam logic [4:0]       CRED_MAX = 5'(CREDITS);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] feed_idx_q, feed_idx_d;
  logic             pass_q, pass_d;
  logic [4:0]       credits_q, credits_d;
  tag_t             tag_q [LATENCY];
  logic             feeding;
  logic             accept;
  logic             tags_busy;
  logic             done;

  assign feeding    = (state_q == FEED_ROW) || (state_q == FEED_COL);
  assign in_ready_o = feeding && (credits_q != '0);
  assign accept     = in_valid_i && in_ready_o;

  always_comb begin
    tags_busy = 1'b0;
    for (int i = 0; i < LATENCY; i++) begin
      tags_busy = tags_busy | tag_q[i].vld;
    end
  end

  always_comb begin
    state_d    = state_q;
    feed_idx_d = feed_idx_q;
    pass_d     = pass_q;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d    = FEED_ROW;
          feed_idx_d = '0;
          pass_d     = 1'b0;
        end
      end
      FEED_ROW, FEED_COL: begin
        if (accept) begin
          if (feed_idx_q == LAST_IDX) begin
            feed_idx_d = '0;
            state_d    = (state_q == FEED_ROW) ? DRAIN_ROW : DRAIN_COL;
          end else begin
            feed_idx_d = feed_idx_q + 1'b1;
          end
        end
      end
      // Column reads must wait until every row result has landed in the transpose buffer.
      DRAIN_ROW: begin
        if (!tags_busy) begin
          state_d = FEED_COL;
          pass_d  = 1'b1;
        end
      end
      DRAIN_COL: begin
        if (!tags_busy) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
        pass_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    credits_d = credits_q;
    if (accept && !buf_pop_i) begin
      credits_d = credits_q - 5'd1;
    end else if (!accept && buf_pop_i && (credits_q != CRED_MAX)) begin
      credits_d = credits_q + 5'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      feed_idx_q <= '0;
      pass_q     <= 1'b0;
      credits_q  <= CRED_MAX;
      for (int i = 0; i < LATENCY; i++) tag_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      feed_idx_q <= feed_idx_d;
      pass_q     <= pass_d;
      credits_q  <= credits_d;
      tag_q[0]   <= '{vld: accept, pass: pass_q, idx: feed_idx_q};
      for (int i = 1; i < LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign busy_o       = (state_q != IDLE);
  assign err_start_o  = start_i && busy_o;
  assign core_load_o  = accept;
  assign pass_o       = pass_q;
  assign feed_idx_o   = feed_idx_q;
  assign credits_o    = credits_q;
  assign block_done_o = done;
  assign cap_en_o     = tag_q[LATENCY-1].vld;
  assign cap_pass_o   = tag_q[LATENCY-1].pass;
  assign cap_idx_o    = tag_q[LATENCY-1].idx;

endmodule

// File: doc/dct16_seq.md
Name: dct16_seq

Overview:
Sequencing controller for the 16-point DCT core in the 2D transform path. It drives a 16x16 block through the core in two passes: 16 row vectors (pass 0), then 16 column vectors read back from the transpose buffer (pass 1). It issues the core load strobe and tracks the core's fixed pipeline latency with a tag delay line. It produces capture strobes and indices for the result/transpose buffer, and throttles input with a credit counter, because the core itself cannot stall.

Parameters:
LATENCY, 6, cycles from a core_load cycle to valid core y outputs; must equal the core pipeline depth, legal range 2..15
ROWS, 16, vectors per pass; fixed by the core size
CREDITS, 8, result-buffer entries available downstream, legal range 1..31
IDX_W, 4, width of the row/column index, log2(ROWS)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin a 2D block; sampled only in IDLE
busy  out  1  high in every state except IDLE
err_start  out  1  one-cycle pulse when start is seen while busy (that start is ignored)
in_valid  in  1  source (input regs or transpose buffer) presents a vector
in_ready  out  1  controller accepts a vector this cycle
core_load  out  1  load strobe to the DCT core
pass  out  1  current feed pass; 0 = rows, 1 = columns
feed_idx  out  IDX_W  index of the vector being requested or fed
cap_en  out  1  core outputs are valid; write them to the buffer
cap_pass  out  1  pass tag of the captured vector
cap_idx  out  IDX_W  index tag of the captured vector
buf_pop  in  1  downstream freed one buffer entry
credits  out  5  current free-entry count
block_done  out  1  one-cycle pulse when the block completes

Behaviour:
- Reset values: all outputs are 0, except credits = CREDITS. The state is IDLE and the tag delay line is cleared.
- Reset mid-block: everything returns to the reset values on the next edge. No cap_en is emitted for vectors that were in flight.
- States: IDLE, FEED_ROW, DRAIN_ROW, FEED_COL, DRAIN_COL, DONE.
- IDLE: in_ready = 0.
  - start -> FEED_ROW, with feed_idx = 0 and pass = 0.
- FEED_ROW / FEED_COL:
  - in_ready = (credits != 0). It is decoded from registered state only; there is no combinational path from in_valid.
  - Accept = in_valid & in_ready. core_load = accept, combinationally in the same cycle.
  - On accept, feed_idx increments.
  - On the accept with feed_idx == ROWS-1: feed_idx wraps to 0 and the state moves to DRAIN_ROW / DRAIN_COL.
- DRAIN_ROW: in_ready = 0. When no valid tag remains in the delay line and cap_en is not asserted this cycle -> FEED_COL, with pass = 1.
  - This guarantees the transpose buffer is fully written before column reads begin.
- DRAIN_COL: same drain condition -> DONE.
- DONE: block_done = 1 for exactly one cycle -> IDLE. busy drops in the following cycle.
- Tag delay line:
  - LATENCY stages, each holding {valid, pass, idx}.
  - An accept at cycle t gives cap_en = 1 at cycle t+LATENCY, with cap_pass and cap_idx equal to the pass and feed_idx at t.
  - Throughput is one vector per cycle. Back-to-back accepts produce back-to-back cap_en.
- Credits:
  - Accept alone: decrement.
  - buf_pop alone: increment.
  - Both in the same cycle: unchanged.
  - buf_pop when credits == CREDITS is ignored (saturate, no wrap).
  - Credits never go below 0, because in_ready blocks accepts at 0.
  - Credits persist across blocks and are reset only by rst.
- start while busy: err_start pulses; the state is unaffected.
- start in the same cycle as block_done: not seen (the state is still DONE) and flagged as err_start.
- in_valid outside the FEED states: ignored; no core_load.

Test Plan:
1. Nominal block (LATENCY=6, CREDITS=8, buf_pop tied high, in_valid always high): start at cycle 0 -> first core_load at 1. cap_en pass0 idx0 at 7. pass flips to 1 after the last row cap_en. block_done pulses once. 32 cap_en total with idx 0..15 per pass.
2. Credit stall (buf_pop=0, CREDITS=8): exactly 8 accepts, then in_ready=0 and credits=0. A single buf_pop pulse -> exactly one more accept. A simultaneous accept+pop keeps credits constant.
3. Bursty source (in_valid toggling 1,0,1,0): feed_idx advances only on accepts. The cap_en pattern is the same toggle pattern delayed 6 cycles. The tags match the accepted idx.
4. Drain ordering: the first pass-1 core_load occurs strictly after the cap_en with cap_pass=0, cap_idx=15. No core_load occurs in DRAIN states, even with in_valid=1.
5. Reset mid-operation: assert rst at feed_idx=9 of the row pass with 5 tags in flight -> the next cycle shows busy=0, credits=8, and no cap_en for 10 cycles. A new start runs a clean block.
6. start while busy and saturating pop: start pulsed during FEED_COL -> err_start=1 for one cycle and the block completes normally. buf_pop with credits=8 -> credits stays 8.
